// File: rtl/add8_share_arb_if.sv
// Bus bundle for add8_share_arb: requester handshake, shared-adder link and response port.
interface add8_share_arb_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
);

  // Requester side
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [8*NREQ-1:0] req_a;
  logic [8*NREQ-1:0] req_b;

  // Shared external 8-bit adder
  logic [7:0]        add_a;
  logic [7:0]        add_b;
  logic [8:0]        add_o;

  // Response side
  logic              rsp_valid;
  logic              rsp_ready;
  logic [8:0]        rsp_sum;
  logic [IDW-1:0]    rsp_id;
  logic [15:0]       done_cnt;

  // Arbiter view
  modport slave (
    input  req_valid,
    input  req_a,
    input  req_b,
    input  add_o,
    input  rsp_ready,
    output req_ready,
    output add_a,
    output add_b,
    output rsp_valid,
    output rsp_sum,
    output rsp_id,
    output done_cnt
  );

  // Requester / adder / consumer view
  modport master (
    output req_valid,
    output req_a,
    output req_b,
    output add_o,
    output rsp_ready,
    input  req_ready,
    input  add_a,
    input  add_b,
    input  rsp_valid,
    input  rsp_sum,
    input  rsp_id,
    input  done_cnt
  );

endinterface

// File: rtl/add8_share_arb.sv
// Round-robin arbiter sharing one external 8-bit adder among NREQ requesters.
// One operation in flight: grant (IDLE) -> adder evaluates (CALC) -> hold result (RESP).
module add8_share_arb #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic             clk,
  input  logic             rst,
  add8_share_arb_if.slave  bus
);

  localparam int unsigned OPW  = 8;
  localparam int unsigned SUMW = 9;
  localparam int unsigned CNTW = 16;
  localparam logic [CNTW-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state;
  logic [IDW-1:0]      last_grant;
  logic [IDW-1:0]      cur_id;
  logic [OPW-1:0]      op_a;
  logic [OPW-1:0]      op_b;
  logic                rsp_valid_q;
  logic [SUMW-1:0]     rsp_sum_q;
  logic [IDW-1:0]      rsp_id_q;
  logic [CNTW-1:0]     done_q;

  logic                grant_any;
  logic [IDW-1:0]      grant_idx;
  logic [OPW-1:0]      sel_a;
  logic [OPW-1:0]      sel_b;
  logic [NREQ-1:0]     ready_c;
  int unsigned         cand;
  logic [IDW-1:0]      cand_idx;

  // Round-robin search starting one past the previous winner
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = 32'(last_grant) + k;
      if (cand >= NREQ) begin
        cand = cand - NREQ;
      end
      cand_idx = IDW'(cand);
      if (!grant_any && bus.req_valid[cand_idx]) begin
        grant_any = 1'b1;
        grant_idx = cand_idx;
      end
    end
  end

  // Operand mux for the winning requester
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (IDW'(i) == grant_idx) begin
        sel_a = bus.req_a[OPW*i +: OPW];
        sel_b = bus.req_b[OPW*i +: OPW];
      end
    end
  end

  // Same-cycle accept: only in IDLE, never while reset is asserted
  always_comb begin
    ready_c = '0;
    if ((state == IDLE) && !rst && grant_any) begin
      ready_c[grant_idx] = 1'b1;
    end
  end

  // Control FSM with operand, result and completion-counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_grant  <= IDW'(NREQ - 1);
      cur_id      <= '0;
      op_a        <= '0;
      op_b        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_id_q    <= '0;
      done_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            op_a       <= sel_a;
            op_b       <= sel_b;
            cur_id     <= grant_idx;
            last_grant <= grant_idx;
            state      <= CALC;
          end
        end
        CALC: begin
          // adder output is taken as-is, approximation errors included
          rsp_sum_q   <= bus.add_o;
          rsp_id_q    <= cur_id;
          rsp_valid_q <= 1'b1;
          state       <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= IDLE;
            if (done_q != CNT_MAX) begin
              done_q <= done_q + CNTW'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = ready_c;
  assign bus.add_a     = op_a;
  assign bus.add_b     = op_b;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_sum   = rsp_sum_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.done_cnt  = done_q;

endmodule
